router_1x3: RTL and testbench

// 1-input/3-output packet router core. Accepts byte-serial packets on data_in.

---
 rtl/router_1x3_if.sv | 30 +++
 rtl/router_1x3.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_router_1x3.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_1x3_if.sv
// rtl/router_1x3_if.sv - Byte-stream input and three read ports of the 1x3 packet router
interface router_1x3_if #(
    parameter int WIDTH = 8
);
    logic             pkt_valid;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             err;
    logic             read_enb_0;
    logic             read_enb_1;
    logic             read_enb_2;
    logic             vld_out_0;
    logic             vld_out_1;
    logic             vld_out_2;
    logic [WIDTH-1:0] data_out_0;
    logic [WIDTH-1:0] data_out_1;
    logic [WIDTH-1:0] data_out_2;

    modport master (
        output pkt_valid, data_in, read_enb_0, read_enb_1, read_enb_2,
        input  busy, err, vld_out_0, vld_out_1, vld_out_2,
        input  data_out_0, data_out_1, data_out_2
    );

    modport slave (
        input  pkt_valid, data_in, read_enb_0, read_enb_1, read_enb_2,
        output busy, err, vld_out_0, vld_out_1, vld_out_2,
        output data_out_0, data_out_1, data_out_2
    );
endinterface

// File: rtl/router_1x3.sv
// rtl/router_1x3.sv - 1-input/3-output packet router: control FSM, header/parity regs, idle timers, output FIFOs
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_rst,
    input  logic             we,
    input  logic [WIDTH:0]   wdata,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH:0] mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           do_wr;
    logic           do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = we && !full;
    assign do_rd = re && !empty;

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else if (soft_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + AW'(1);
                dout <= mem[rptr][WIDTH-1:0];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end
endmodule

module router_1x3 #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int SOFT_TOUT = 30
) (
    input  logic         clock,
    input  logic         resetn,
    router_1x3_if.slave  bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

    localparam int TW = $clog2(SOFT_TOUT);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hdr_q;
    logic [WIDTH-1:0] par_q;
    logic [WIDTH-1:0] rx_par_q;
    logic [WIDTH-1:0] hold_q;
    logic [1:0]       addr_q;
    logic             err_q;
    logic             done_q;

    logic [2:0]       full;
    logic [2:0]       empty;
    logic [2:0]       fifo_re;
    logic [2:0]       fifo_we;
    logic [2:0]       soft_rst;
    logic [3:0]       full_ext;
    logic [3:0]       empty_ext;
    logic [3:0]       soft_ext;
    logic             wr_en;
    logic [WIDTH:0]   wr_data;
    logic             busy;

    logic [1:0]       hdr_addr;
    logic             hdr_ok;
    logic             hdr_empty;
    logic             tgt_full;
    logic             tgt_empty;
    logic             abort;

    // Address 3 has no FIFO; padding the vectors keeps every 2-bit index in range.
    assign full_ext  = {1'b0, full};
    assign empty_ext = {1'b1, empty};
    assign soft_ext  = {1'b0, soft_rst};

    assign hdr_addr  = bus.data_in[1:0];
    assign hdr_ok    = bus.pkt_valid && (hdr_addr != 2'd3);
    assign hdr_empty = empty_ext[hdr_addr];
    assign tgt_full  = full_ext[addr_q];
    assign tgt_empty = empty_ext[addr_q];
    assign abort     = (state_q != DECODE_ADDRESS) && soft_ext[addr_q];
    assign fifo_re   = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

    for (genvar i = 0; i < 3; i++) begin : g_port
        logic [TW-1:0] idle_cnt;
        logic          idle;

        assign idle        = !empty[i] && !fifo_re[i];
        assign soft_rst[i] = idle && (idle_cnt == TW'(SOFT_TOUT - 1));
        assign fifo_we[i]  = wr_en && (addr_q == 2'(i));

        always_ff @(posedge clock or posedge resetn) begin
            if (resetn) begin
                idle_cnt <= '0;
            end else if (idle && !soft_rst[i]) begin
                idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q <= DECODE_ADDRESS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (tgt_empty) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_data = {1'b1, hdr_q};
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (!bus.pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else if (tgt_full) begin
                    state_d = FIFO_FULL_STATE;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = {1'b0, bus.data_in};
                end
            end
            FIFO_FULL_STATE: begin
                busy = 1'b1;
                // done_q: the stall came after the parity byte, so nothing is held.
                if (!tgt_full) begin
                    state_d = done_q ? DECODE_ADDRESS : LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_data = {1'b0, hold_q};
                state_d = bus.pkt_valid ? LOAD_DATA : LOAD_PARITY;
            end
            LOAD_PARITY: begin
                busy = 1'b1;
                if (!tgt_full) begin
                    wr_en   = 1'b1;
                    wr_data = {1'b0, rx_par_q};
                    state_d = CHECK_PARITY_ERROR;
                end
            end
            CHECK_PARITY_ERROR: begin
                busy    = 1'b1;
                state_d = tgt_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        if (abort) begin
            state_d = DECODE_ADDRESS;
            wr_en   = 1'b0;
        end
    end

    // A payload byte that meets a full FIFO has already been taken from the source, so it is held.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            hdr_q    <= '0;
            addr_q   <= '0;
            par_q    <= '0;
            rx_par_q <= '0;
            hold_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_ok) begin
                        hdr_q  <= bus.data_in;
                        addr_q <= hdr_addr;
                        par_q  <= bus.data_in;
                        err_q  <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                LOAD_DATA: begin
                    if (bus.pkt_valid) begin
                        par_q <= par_q ^ bus.data_in;
                        if (tgt_full) begin
                            hold_q <= bus.data_in;
                        end
                    end else begin
                        rx_par_q <= bus.data_in;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (!bus.pkt_valid) begin
                        rx_par_q <= bus.data_in;
                    end
                end
                CHECK_PARITY_ERROR: begin
                    err_q  <= (par_q != rx_par_q);
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO0 (
        .clock    (clock),
        .resetn   (resetn),
        .soft_rst (soft_rst[0]),
        .we       (fifo_we[0]),
        .wdata    (wr_data),
        .re       (fifo_re[0]),
        .dout     (bus.data_out_0),
        .full     (full[0]),
        .empty    (empty[0])
    );

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO1 (
        .clock    (clock),
        .resetn   (resetn),
        .soft_rst (soft_rst[1]),
        .we       (fifo_we[1]),
        .wdata    (wr_data),
        .re       (fifo_re[1]),
        .dout     (bus.data_out_1),
        .full     (full[1]),
        .empty    (empty[1])
    );

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO2 (
        .clock    (clock),
        .resetn   (resetn),
        .soft_rst (soft_rst[2]),
        .we       (fifo_we[2]),
        .wdata    (wr_data),
        .re       (fifo_re[2]),
        .dout     (bus.data_out_2),
        .full     (full[2]),
        .empty    (empty[2])
    );

    assign bus.busy      = busy;
    assign bus.err       = err_q;
    assign bus.vld_out_0 = !empty[0];
    assign bus.vld_out_1 = !empty[1];
    assign bus.vld_out_2 = !empty[2];
endmodule

// File: tb/tb_router_1x3.sv
// tb/tb_router_1x3.sv - Randomized self-checking bench for router_1x3 against a per-port packet queue model
`timescale 1ns/1ps
module tb_router_1x3;
    logic clock  = 1'b0;
    logic resetn = 1'b1;

    router_1x3_if bus ();

    router_1x3 dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q [3][$];
    int         run2      = 0;
    int         last_run2 = 0;

    // Length of the most recent uninterrupted stretch with port 2 valid.
    always @(negedge clock) begin
        if (bus.vld_out_2) begin
            run2++;
        end else begin
            if (run2 != 0) last_run2 = run2;
            run2 = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic vld_of(input int port);
        case (port)
            0:       return bus.vld_out_0;
            1:       return bus.vld_out_1;
            default: return bus.vld_out_2;
        endcase
    endfunction

    function automatic logic [7:0] dout_of(input int port);
        case (port)
            0:       return bus.data_out_0;
            1:       return bus.data_out_1;
            default: return bus.data_out_2;
        endcase
    endfunction

    task automatic set_re(input int port, input logic v);
        case (port)
            0:       bus.read_enb_0 = v;
            1:       bus.read_enb_1 = v;
            default: bus.read_enb_2 = v;
        endcase
    endtask

    // Builds header/payload/parity, records it in the model, then drives it honouring busy.
    task automatic send_pkt(input logic [1:0] addr, input int len, input bit corrupt,
                            output int busy_cycles);
        logic [7:0] b[$];
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] p;
        int         guard;
        hdr = {len[5:0], addr};
        b.push_back(hdr);
        par = hdr;
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom_range(0, 255));
            if (addr == 2'd3) p[1:0] = 2'd3;
            b.push_back(p);
            par ^= p;
        end
        b.push_back(corrupt ? (par ^ 8'h5A) : par);
        if (addr != 2'd3) begin
            foreach (b[k]) model_q[addr].push_back(b[k]);
        end
        busy_cycles = 0;
        for (int i = 0; i < b.size(); i++) begin
            bus.data_in   = b[i];
            bus.pkt_valid = (i < b.size() - 1);
            #1;
            guard = 0;
            while (bus.busy === 1'b1 && guard < 200) begin
                busy_cycles++;
                guard++;
                @(negedge clock);
                #1;
            end
            if (guard >= 200) begin
                check("send_busy_timeout", 32'(bus.busy), 32'd0);
                bus.pkt_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        bus.pkt_valid = 1'b0;
    endtask

    task automatic read_port(input int port, input int n, input string tag);
        int         guard;
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!vld_of(port) && guard < 100) begin
                guard++;
                @(negedge clock);
            end
            if (!vld_of(port)) begin
                check({tag, "_vld_timeout"}, 32'(vld_of(port)), 32'd1);
                return;
            end
            set_re(port, 1'b1);
            @(negedge clock);
            set_re(port, 1'b0);
            exp = model_q[port].pop_front();
            check(tag, 32'(dout_of(port)), 32'(exp));
        end
    endtask

    int bc;
    int bc3;
    int len;
    int guard;

    initial begin
        bus.pkt_valid  = 1'b0;
        bus.data_in    = 8'h00;
        bus.read_enb_0 = 1'b0;
        bus.read_enb_1 = 1'b0;
        bus.read_enb_2 = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_vld", 32'({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}), 32'd0);
        check("reset_dout", 32'({bus.data_out_2, bus.data_out_1, bus.data_out_0}), 32'd0);
        resetn = 1'b0;
        repeat (2) @(negedge clock);

        // T1: 16-entry packet to port 1 with reads held off
        send_pkt(2'd1, 14, 1'b0, bc);
        check("t1_busy_during_payload", 32'(bc), 32'd1);
        repeat (3) @(negedge clock);
        check("t1_vld1", 32'(bus.vld_out_1), 32'd1);
        check("t1_vld0", 32'(bus.vld_out_0), 32'd0);
        check("t1_full", 32'(dut.FIFO1.full), 32'(model_q[1].size() == 16));
        check("t1_err", 32'(bus.err), 32'd0);

        // T2: drain port 1
        read_port(1, 16, "t2_data");
        check("t2_vld1_empty", 32'(bus.vld_out_1), 32'd0);
        repeat (3) @(negedge clock);

        // T3: packet larger than the FIFO, drained while the source is stalled
        fork
            send_pkt(2'd1, 16, 1'b0, bc3);
            begin
                repeat (22) @(negedge clock);
                read_port(1, 18, "t3_data");
            end
        join
        check("t3_busy_stall", 32'(bc3 > 1), 32'd1);
        repeat (3) @(negedge clock);
        check("t3_vld1_empty", 32'(bus.vld_out_1), 32'd0);
        check("t3_err", 32'(bus.err), 32'd0);

        // T4: corrupted parity then a good packet
        send_pkt(2'd1, 6, 1'b1, bc);
        repeat (3) @(negedge clock);
        check("t4_err_set", 32'(bus.err), 32'd1);
        read_port(1, 8, "t4_data");
        check("t4_err_hold", 32'(bus.err), 32'd1);
        len = $urandom_range(1, 12);
        send_pkt(2'd0, len, 1'b0, bc);
        repeat (3) @(negedge clock);
        check("t4_err_clear", 32'(bus.err), 32'd0);
        read_port(0, len + 2, "t4_good_data");

        // T5: idle port 2 is soft-reset; addr 3 is dropped
        len = $urandom_range(1, 10);
        send_pkt(2'd2, len, 1'b0, bc);
        guard = 0;
        while (bus.vld_out_2 && guard < 80) begin
            guard++;
            @(negedge clock);
        end
        check("t5_soft_clear", 32'(bus.vld_out_2), 32'd0);
        @(negedge clock);
        check("t5_idle_len", 32'(last_run2), 32'd30);
        check("t5_busy_idle", 32'(bus.busy), 32'd0);
        model_q[2].delete();
        send_pkt(2'd3, 4, 1'b0, bc);
        check("t5_addr3_busy", 32'(bc), 32'd0);
        repeat (2) @(negedge clock);
        check("t5_addr3_nowrite", 32'({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}), 32'd0);

        // T6: asynchronous reset in the middle of a payload
        send_pkt(2'd2, 3, 1'b1, bc);
        repeat (3) @(negedge clock);
        check("t6_err_before", 32'(bus.err), 32'd1);
        bus.data_in   = {6'd10, 2'd0};
        bus.pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.data_in = 8'($urandom_range(0, 255));
        end
        check("t6_pre_vld0", 32'(bus.vld_out_0), 32'd1);
        #2;
        resetn = 1'b1;
        #1;
        check("t6_async_vld", 32'({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}), 32'd0);
        check("t6_async_busy", 32'(bus.busy), 32'd0);
        check("t6_async_err", 32'(bus.err), 32'd0);
        check("t6_async_dout", 32'({bus.data_out_2, bus.data_out_1, bus.data_out_0}), 32'd0);
        @(negedge clock);
        bus.pkt_valid = 1'b0;
        model_q[0].delete();
        model_q[2].delete();
        repeat (2) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        len = $urandom_range(1, 13);
        send_pkt(2'd0, len, 1'b0, bc);
        repeat (3) @(negedge clock);
        check("t6_recover_err", 32'(bus.err), 32'd0);
        read_port(0, len + 2, "t6_recover_data");
        check("t6_recover_empty", 32'(bus.vld_out_0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
